// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined CORDIC rotation core
// among NREQ requesters, with a tag line returning results by ID.
module cordic_rr_arbiter #(
  parameter int SZ   = 16,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int LAT  = 16
) (
  input  logic               CLK_100MHZ,
  input  logic               rst_n,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_angle,
  input  logic [NREQ*SZ-1:0] req_x,
  input  logic [NREQ*SZ-1:0] req_y,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        cor_angle,
  output logic [SZ-1:0]      cor_x,
  output logic [SZ-1:0]      cor_y,
  input  logic [SZ:0]        cor_xout,
  input  logic [SZ:0]        cor_yout,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [SZ:0]        rsp_x,
  output logic [SZ:0]        rsp_y,
  output logic               busy
);

  logic [IDW-1:0] r_ptr;
  logic [31:0]    r_ang;
  logic [SZ-1:0]  r_x;
  logic [SZ-1:0]  r_y;
  logic [LAT:0]   r_tv;
  logic [IDW-1:0] r_tid [LAT+1];
  logic           r_rv;
  logic [IDW-1:0] r_rid;
  logic [SZ:0]    r_rx;
  logic [SZ:0]    r_ry;

  logic [IDW-1:0] w_gidx;
  logic [IDW-1:0] w_idx;
  logic           w_hs;

  // Search starts one past the last winner so every requester rotates in.
  always_comb begin
    w_gidx = r_ptr;
    w_idx  = r_ptr;
    w_hs   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_hs && req_valid[w_idx]) begin
        w_hs   = 1'b1;
        w_gidx = w_idx;
      end
    end
    if (hold || !rst_n) w_hs = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (w_hs) req_ready[w_gidx] = 1'b1;
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (!rst_n) begin
      r_ptr <= IDW'(NREQ - 1);
      r_ang <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_tv  <= '0;
      r_rv  <= 1'b0;
      r_rid <= '0;
      r_rx  <= '0;
      r_ry  <= '0;
    end else begin
      r_tv  <= {r_tv[LAT-1:0], w_hs};
      r_rv  <= r_tv[LAT];
      r_rid <= r_tid[LAT];
      r_rx  <= cor_xout;
      r_ry  <= cor_yout;
      if (w_hs) begin
        r_ptr <= w_gidx;
        r_ang <= req_angle[32*w_gidx +: 32];
        r_x   <= req_x[SZ*w_gidx +: SZ];
        r_y   <= req_y[SZ*w_gidx +: SZ];
      end else begin
        r_ang <= '0;
        r_x   <= '0;
        r_y   <= '0;
      end
    end
  end

  // IDs are qualified by r_tv, so they need no reset.
  always_ff @(posedge CLK_100MHZ) begin
    r_tid[0] <= w_gidx;
    for (int i = 1; i <= LAT; i++) r_tid[i] <= r_tid[i-1];
  end

  assign cor_angle = r_ang;
  assign cor_x     = r_x;
  assign cor_y     = r_y;
  assign rsp_valid = r_rv;
  assign rsp_id    = r_rid;
  assign rsp_x     = r_rx;
  assign rsp_y     = r_ry;
  assign busy      = |r_tv;

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter with a behavioural
// fixed-latency CORDIC model and a response scoreboard.
module tb_cordic_rr_arbiter;
  localparam int SZ = 16;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int LAT = 16;

  logic clk = 1'b0;
  logic rst_n, hold;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*32-1:0] req_angle;
  logic [NREQ*SZ-1:0] req_x, req_y;
  logic [31:0] cor_angle;
  logic [SZ-1:0] cor_x, cor_y;
  logic [SZ:0] cor_xout, cor_yout;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [SZ:0] rsp_x, rsp_y;
  logic busy;

  always #5 clk = ~clk;

  cordic_rr_arbiter #(.SZ(SZ), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .CLK_100MHZ(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_angle(req_angle),
    .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .cor_angle(cor_angle), .cor_x(cor_x), .cor_y(cor_y),
    .cor_xout(cor_xout), .cor_yout(cor_yout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void rot(input logic [31:0] a,
                              input logic signed [15:0] x,
                              input logic signed [15:0] y,
                              output logic [16:0] ox,
                              output logic [16:0] oy);
    real th, xr, yr, rx, ry;
    int ix, iy;
    th = ($itor(a[31:16]) * 65536.0 + $itor(a[15:0]))
         * 6.283185307179586 / 4294967296.0;
    xr = $itor(x);
    yr = $itor(y);
    rx = 1.646760258 * (xr * $cos(th) - yr * $sin(th));
    ry = 1.646760258 * (xr * $sin(th) + yr * $cos(th));
    ix = $rtoi(rx + (rx >= 0.0 ? 0.5 : -0.5));
    iy = $rtoi(ry + (ry >= 0.0 ? 0.5 : -0.5));
    ox = ix[16:0];
    oy = iy[16:0];
  endfunction

  // behavioural CORDIC: LAT edges from cor_* to cor_xout/yout
  logic [16:0] px [LAT];
  logic [16:0] py [LAT];
  always @(posedge clk) begin
    logic [16:0] tx, ty;
    rot(cor_angle, cor_x, cor_y, tx, ty);
    px[0] <= tx;
    py[0] <= ty;
    for (int i = 1; i < LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign cor_xout = px[LAT-1];
  assign cor_yout = py[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [16:0] x;
    logic [16:0] y;
    int          t;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e, g;
    if (rst_n === 1'b1 && |(req_valid & req_ready)) begin
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) e.id = 2'(i);
      rot(req_angle[32*e.id +: 32], req_x[16*e.id +: 16],
          req_y[16*e.id +: 16], e.x, e.y);
      e.t = cyc + LAT + 2;
      sb.push_back(e);
    end
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id %0d want none", rsp_id);
      end else begin
        g = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(g.id));
        chk("rsp_x", 64'(rsp_x), 64'(g.x));
        chk("rsp_y", 64'(rsp_y), 64'(g.y));
        chk("rsp_cycle", 64'(cyc), 64'(g.t));
      end
    end
  end

  typedef struct {
    logic [3:0] v;
    logic       h;
    logic [3:0] rdy;
  } vec_t;
  vec_t tbl[20];

  function automatic logic [95:0] slice(input logic [3:0] r);
    logic [95:0] s;
    s = '0;
    for (int i = 0; i < NREQ; i++)
      if (r[i])
        s = {req_angle[32*i +: 32], 16'd0, req_x[16*i +: 16],
             16'd0, req_y[16*i +: 16]};
    return s;
  endfunction

  initial begin
    logic [95:0] es;
    int n, cnt, d;
    bit found;

    tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[7]  = '{4'b1111, 1'b0, 4'b1000};
    tbl[8]  = '{4'b1010, 1'b0, 4'b0010};
    tbl[9]  = '{4'b1010, 1'b0, 4'b1000};
    tbl[10] = '{4'b1010, 1'b0, 4'b0010};
    tbl[11] = '{4'b1010, 1'b0, 4'b1000};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100};
    tbl[13] = '{4'b0100, 1'b0, 4'b0100};
    tbl[14] = '{4'b1111, 1'b1, 4'b0000};
    tbl[15] = '{4'b1111, 1'b1, 4'b0000};
    tbl[16] = '{4'b1111, 1'b0, 4'b1000};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000};
    tbl[18] = '{4'b0001, 1'b0, 4'b0001};
    tbl[19] = '{4'b1001, 1'b0, 4'b1000};

    for (int i = 0; i < NREQ; i++) begin
      req_angle[32*i +: 32] = 32'(i * 32'h1000_0000 + 32'h0123_4567);
      req_x[16*i +: 16] = 16'(3000 + 1111 * i);
      req_y[16*i +: 16] = 16'(-2000 + 777 * i);
    end
    rst_n = 1'b0;
    hold = 1'b0;
    req_valid = 4'b1111;

    // reset with all requesting
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
    end
    chk("rst_cor_angle", 64'(cor_angle), 64'd0);
    chk("rst_cor_x", 64'(cor_x), 64'd0);
    chk("rst_cor_y", 64'(cor_y), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // contention, fairness/wrap, lone requester, hold
    for (int i = 0; i < 20; i++) begin
      req_valid = tbl[i].v;
      hold = tbl[i].h;
      #1;
      chk($sformatf("ready[%0d]", i), 64'(req_ready), 64'(tbl[i].rdy));
      es = slice(tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("cor_angle[%0d]", i), 64'(cor_angle), 64'(es[95:64]));
      chk($sformatf("cor_x[%0d]", i), 64'(cor_x), 64'(es[47:32]));
      chk($sformatf("cor_y[%0d]", i), 64'(cor_y), 64'(es[15:0]));
    end
    req_valid = 4'b0000;
    hold = 1'b0;

    n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);

    // single request, 45 degrees
    req_angle[32*2 +: 32] = 32'h2000_0000;
    req_x[16*2 +: 16] = 16'd19429;
    req_y[16*2 +: 16] = 16'd0;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    chk("single_cor_angle", 64'(cor_angle), 64'h2000_0000);
    chk("single_cor_x", 64'(cor_x), 64'd19429);
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == LAT) chk("single_busy_before", 64'(busy), 64'd1);
      if (rsp_valid) found = 1'b1;
    end
    chk("single_latency", 64'(n), 64'(LAT + 1));
    chk("single_id", 64'(rsp_id), 64'd2);
    d = int'($signed(rsp_x)) - 22627;
    chk("single_x_tol", 64'(d >= -4 && d <= 4), 64'd1);
    d = int'($signed(rsp_y)) - 22627;
    chk("single_y_tol", 64'(d >= -4 && d <= 4), 64'd1);
    chk("single_busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("single_strobe_len", 64'(rsp_valid), 64'd0);

    // reset mid-flight
    req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    chk("mid_busy", 64'(busy), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_busy_cleared", 64'(busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) cnt++;
    end
    chk("mid_no_rsp", 64'(cnt), 64'd0);
    chk("mid_busy_end", 64'(busy), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("mid_first_grant", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (25) @(posedge clk);
    #1;
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
